// File: rtl/fft_bfly_ctrl.sv
// fft_bfly_ctrl: sequences one radix-2 butterfly (X = A + W*B, Y = A - W*B) over a shared complex unit.
// Optional feature macro BFLY_TWIDDLE_BYPASS_EN: a unity twiddle (w_one=1) skips the multiply and uses T = B.
module fft_bfly_ctrl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  input  logic [DW-1:0] w_re,
  input  logic [DW-1:0] w_im,
  input  logic          w_one,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] x_re,
  output logic [DW-1:0] x_im,
  output logic [DW-1:0] y_re,
  output logic [DW-1:0] y_im,
  output logic [DW-1:0] cop_re1,
  output logic [DW-1:0] cop_im1,
  output logic [DW-1:0] cop_re2,
  output logic [DW-1:0] cop_im2,
  output logic          cop_op,
  output logic          cop_start,
  input  logic [DW-1:0] cop_re,
  input  logic [DW-1:0] cop_im,
  input  logic          cop_ready
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_ISS  = 3'd1,
    ST_MUL_WAIT = 3'd2,
    ST_ADD_ISS  = 3'd3,
    ST_ADD_WAIT = 3'd4,
    ST_SUB_ISS  = 3'd5,
    ST_SUB_WAIT = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  localparam logic [DW-1:0] ZERO = {DW{1'b0}};

  state_t state_r, state_s;
  logic [DW-1:0] a_re_r, a_im_r, b_re_r, b_im_r, w_re_r, w_im_r, t_re_r, t_im_r;
  logic [DW-1:0] a_re_s, a_im_s, b_re_s, b_im_s, w_re_s, w_im_s, t_re_s, t_im_s;
  logic [DW-1:0] x_re_s, x_im_s, y_re_s, y_im_s;
  logic [DW-1:0] cop_re1_s, cop_im1_s, cop_re2_s, cop_im2_s;
  logic          busy_s, done_s, cop_op_s, cop_start_s;

`ifndef BFLY_TWIDDLE_BYPASS_EN
  logic unused_s;
  assign unused_s = w_one;
`endif

  // IEEE-754 negation: only the sign bit changes, so +0 becomes -0.
  function automatic logic [DW-1:0] flip_sign(input logic [DW-1:0] v);
    return {~v[DW-1], v[DW-2:0]};
  endfunction

  // Next state, operand capture and result capture.
  always_comb begin
    state_s = state_r;
    a_re_s = a_re_r;  a_im_s = a_im_r;
    b_re_s = b_re_r;  b_im_s = b_im_r;
    w_re_s = w_re_r;  w_im_s = w_im_r;
    t_re_s = t_re_r;  t_im_s = t_im_r;
    x_re_s = x_re;    x_im_s = x_im;
    y_re_s = y_re;    y_im_s = y_im;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          a_re_s = a_re;  a_im_s = a_im;
          b_re_s = b_re;  b_im_s = b_im;
          w_re_s = w_re;  w_im_s = w_im;
`ifdef BFLY_TWIDDLE_BYPASS_EN
          if (w_one) begin
            t_re_s  = b_re;
            t_im_s  = b_im;
            state_s = ST_ADD_ISS;
          end else begin
            state_s = ST_MUL_ISS;
          end
`else
          state_s = ST_MUL_ISS;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL_ISS: state_s = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (cop_ready) begin
          t_re_s  = cop_re;
          t_im_s  = cop_im;
          state_s = ST_ADD_ISS;
        end else begin
          state_s = ST_MUL_WAIT;
        end
      end
      ST_ADD_ISS: state_s = ST_ADD_WAIT;
      ST_ADD_WAIT: begin
        if (cop_ready) begin
          x_re_s  = cop_re;
          x_im_s  = cop_im;
          state_s = ST_SUB_ISS;
        end else begin
          state_s = ST_ADD_WAIT;
        end
      end
      ST_SUB_ISS: state_s = ST_SUB_WAIT;
      ST_SUB_WAIT: begin
        if (cop_ready) begin
          y_re_s  = cop_re;
          y_im_s  = cop_im;
          state_s = ST_DONE;
        end else begin
          state_s = ST_SUB_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they can be registered alongside it.
  always_comb begin
    busy_s      = (state_s != ST_IDLE);
    done_s      = (state_s == ST_DONE);
    cop_start_s = (state_s == ST_MUL_ISS) || (state_s == ST_ADD_ISS) || (state_s == ST_SUB_ISS);
    cop_op_s    = cop_op;
    cop_re1_s   = cop_re1;  cop_im1_s = cop_im1;
    cop_re2_s   = cop_re2;  cop_im2_s = cop_im2;
    case (state_s)
      ST_MUL_ISS, ST_MUL_WAIT: begin
        cop_op_s  = 1'b0;
        cop_re1_s = w_re_s;  cop_im1_s = w_im_s;
        cop_re2_s = b_re_s;  cop_im2_s = b_im_s;
      end
      ST_ADD_ISS, ST_ADD_WAIT: begin
        cop_op_s  = 1'b1;
        cop_re1_s = a_re_s;  cop_im1_s = a_im_s;
        cop_re2_s = t_re_s;  cop_im2_s = t_im_s;
      end
      ST_SUB_ISS, ST_SUB_WAIT: begin
        cop_op_s  = 1'b1;
        cop_re1_s = a_re_s;             cop_im1_s = a_im_s;
        cop_re2_s = flip_sign(t_re_s);  cop_im2_s = flip_sign(t_im_s);
      end
      default: begin
        cop_op_s  = cop_op;
        cop_re1_s = cop_re1;  cop_im1_s = cop_im1;
        cop_re2_s = cop_re2;  cop_im2_s = cop_im2;
      end
    endcase
  end

  // State, operand and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_re_r <= ZERO;  a_im_r <= ZERO;  b_re_r <= ZERO;  b_im_r <= ZERO;
      w_re_r <= ZERO;  w_im_r <= ZERO;  t_re_r <= ZERO;  t_im_r <= ZERO;
      x_re <= ZERO;  x_im <= ZERO;  y_re <= ZERO;  y_im <= ZERO;
      cop_re1 <= ZERO;  cop_im1 <= ZERO;  cop_re2 <= ZERO;  cop_im2 <= ZERO;
      busy <= 1'b0;  done <= 1'b0;  cop_op <= 1'b0;  cop_start <= 1'b0;
    end else begin
      state_r <= state_s;
      a_re_r <= a_re_s;  a_im_r <= a_im_s;  b_re_r <= b_re_s;  b_im_r <= b_im_s;
      w_re_r <= w_re_s;  w_im_r <= w_im_s;  t_re_r <= t_re_s;  t_im_r <= t_im_s;
      x_re <= x_re_s;  x_im <= x_im_s;  y_re <= y_re_s;  y_im <= y_im_s;
      cop_re1 <= cop_re1_s;  cop_im1 <= cop_im1_s;  cop_re2 <= cop_re2_s;  cop_im2 <= cop_im2_s;
      busy <= busy_s;  done <= done_s;  cop_op <= cop_op_s;  cop_start <= cop_start_s;
    end
  end

endmodule

// File: tb/tb_fft_bfly_ctrl.sv
// Scoreboard bench for fft_bfly_ctrl: integer-valued floats, a latency-programmable complex unit model,
// and a reference that computes X = A + W*B, Y = A - W*B directly.
module tb_fft_bfly_ctrl;
  localparam int DW = 32;
`ifdef BFLY_TWIDDLE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic w_one = 1'b0;
  logic [31:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
  logic busy, done, cop_op, cop_start;
  logic [31:0] x_re, x_im, y_re, y_im, cop_re1, cop_im1, cop_re2, cop_im2;
  logic [31:0] cop_re = '0, cop_im = '0;
  logic cop_ready = 1'b0;

  fft_bfly_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im), .w_one(w_one),
    .busy(busy), .done(done), .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .cop_re1(cop_re1), .cop_im1(cop_im1), .cop_re2(cop_re2), .cop_im2(cop_im2),
    .cop_op(cop_op), .cop_start(cop_start), .cop_re(cop_re), .cop_im(cop_im), .cop_ready(cop_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] xr, xi, yr, yi;
    int nops;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  int ndone = 0;
  int nstart = 0;
  int lat = 1;

  // Single-precision encode/decode of small integers (|v| < 2^23).
  function automatic logic [31:0] enc(input int v);
    int m, e;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    e = 0;
    for (int i = 0; i < 23; i++) if (m >= (1 << i)) e = i;
    r[31] = (v < 0);
    r[30:23] = 8'(127 + e);
    r[22:0] = 23'((m << (23 - e)) & 32'h007F_FFFF);
    return r;
  endfunction

  function automatic int dec(input logic [31:0] f);
    int e, m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [63:0] ucomp(input logic op, input logic [31:0] r1, i1, r2, i2);
    int a, b, c, d;
    a = dec(r1); b = dec(i1); c = dec(r2); d = dec(i2);
    if (!op) return {enc(a * c - b * d), enc(a * d + b * c)};
    return {enc(a + c), enc(b + d)};
  endfunction

  // Complex unit model: result after 'lat' cycles, garbage on the result bus otherwise.
  bit pend_r = 1'b0;
  int cnt_r = 0;
  logic [63:0] res_r = '0;
  always @(posedge clk) begin
    if (rst) begin
      pend_r <= 1'b0; cnt_r <= 0; cop_ready <= 1'b0; cop_re <= 32'h0; cop_im <= 32'h0;
    end else begin
      cop_ready <= 1'b0;
      cop_re <= $urandom;
      cop_im <= $urandom;
      if (pend_r) begin
        if (cnt_r <= 1) begin
          cop_ready <= 1'b1; {cop_re, cop_im} <= res_r; pend_r <= 1'b0;
        end else begin
          cnt_r <= cnt_r - 1;
        end
      end
      if (cop_start) begin
        if (lat <= 1) begin
          cop_ready <= 1'b1;
          {cop_re, cop_im} <= ucomp(cop_op, cop_re1, cop_im1, cop_re2, cop_im2);
        end else begin
          pend_r <= 1'b1; cnt_r <= lat - 1;
          res_r <= ucomp(cop_op, cop_re1, cop_im1, cop_re2, cop_im2);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts unit starts, pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        nstart = 0;
      end else begin
        if (cop_start) begin
          chk("start_while_unit_busy", 32'(pend_r || cop_ready), 32'd0);
          nstart++;
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("x_re", x_re, e.xr);
            chk("x_im", x_im, e.xi);
            chk("y_re", y_re, e.yr);
            chk("y_im", y_im, e.yi);
            chk("unit_ops", 32'(nstart), 32'(e.nops));
            chk("busy_at_done", 32'(busy), 32'd1);
          end
          ndone++;
          nstart = 0;
        end
      end
    end
  end

  task automatic push_exp(input int ar, ai, br, bi, wr, wi, input bit wo);
    exp_t e;
    int tr, ti;
    tr = wr * br - wi * bi;
    ti = wr * bi + wi * br;
    e.xr = enc(ar + tr); e.xi = enc(ai + ti);
    e.yr = enc(ar - tr); e.yi = enc(ai - ti);
    e.nops = (BYP && wo) ? 2 : 3;
    q.push_back(e);
  endtask

  task automatic drive(input int ar, ai, br, bi, wr, wi, input bit wo);
    a_re = enc(ar); a_im = enc(ai); b_re = enc(br); b_im = enc(bi);
    w_re = enc(wr); w_im = enc(wi); w_one = wo;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 600 && ndone == d0; i++) @(posedge clk);
    if (ndone == d0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic bfly(input int ar, ai, br, bi, wr, wi, input bit wo);
    int d0;
    d0 = ndone;
    push_exp(ar, ai, br, bi, wr, wi, wo);
    @(posedge clk); #1;
    drive(ar, ai, br, bi, wr, wi, wo);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_re = $urandom; a_im = $urandom; b_re = $urandom; b_im = $urandom;
    w_re = $urandom; w_im = $urandom; w_one = 1'($urandom);
    wait_done(d0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cop_start"}, 32'(cop_start), 32'd0);
    chk({tag, "_cop_op"}, 32'(cop_op), 32'd0);
    chk({tag, "_x_re"}, x_re, 32'd0);
    chk({tag, "_x_im"}, x_im, 32'd0);
    chk({tag, "_y_re"}, y_re, 32'd0);
    chk({tag, "_y_im"}, y_im, 32'd0);
    chk({tag, "_cop_re1"}, cop_re1, 32'd0);
    chk({tag, "_cop_im1"}, cop_im1, 32'd0);
    chk({tag, "_cop_re2"}, cop_re2, 32'd0);
    chk({tag, "_cop_im2"}, cop_im2, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int ar, ai, br, bi, wr, wi;
    bit wo, found;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // A=1+2j, B=3+4j, W=j
    lat = 1;
    bfly(1, 2, 3, 4, 0, 1, 1'b0);
    chk("dir_x_re", x_re, 32'hC040_0000);
    chk("dir_x_im", x_im, 32'h40A0_0000);
    chk("dir_y_re", y_re, 32'h40A0_0000);
    chk("dir_y_im", y_im, 32'hBF80_0000);

    // Unity twiddle with w_one
    bfly(1, 2, 3, 4, 1, 0, 1'b1);
    chk("one_x_re", x_re, 32'h4080_0000);
    chk("one_x_im", x_im, 32'h40C0_0000);
    chk("one_y_re", y_re, 32'hC000_0000);
    chk("one_y_im", y_im, 32'hC000_0000);

    // Same butterfly with a slow unit
    lat = 7;
    bfly(1, 2, 3, 4, 0, 1, 1'b0);

    // start held for 30 cycles: one butterfly only
    lat = 9;
    d0 = ndone;
    push_exp(2, -3, 5, 1, -2, 3, 1'b0);
    @(posedge clk); #1;
    drive(2, -3, 5, 1, -2, 3, 1'b0);
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_busy", 32'(busy), 32'd1);
    repeat (25) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0);
    repeat (40) @(posedge clk);
    chk("hold_one_done", 32'(ndone - d0), 32'd1);

    // Reset during ADD_WAIT abandons the butterfly
    lat = 7;
    d0 = ndone;
    @(posedge clk); #1;
    drive(3, 1, -2, 4, 1, -1, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (cop_start && cop_op) found = 1'b1;
    end
    chk("abort_add_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("abort");
    rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("abort_no_done", 32'(ndone - d0), 32'd0);
    bfly(3, 1, -2, 4, 1, -1, 1'b0);

    // Randomized butterflies with random unit latency
    for (int k = 0; k < 40; k++) begin
      lat = int'($urandom_range(1, 7));
      ar = int'($urandom_range(0, 16)) - 8;  ai = int'($urandom_range(0, 16)) - 8;
      br = int'($urandom_range(0, 16)) - 8;  bi = int'($urandom_range(0, 16)) - 8;
      if ($urandom_range(0, 3) == 0) begin
        wr = 1; wi = 0; wo = 1'b1;
      end else begin
        wr = int'($urandom_range(0, 16)) - 8;  wi = int'($urandom_range(0, 16)) - 8;
        wo = 1'b0;
      end
      bfly(ar, ai, br, bi, wr, wi, wo);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
